// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: parity modes,
// FSM state encoding and the baud divisor calculation.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Terminal count of the bit-period counter; one bit lasts div+1 clocks.
   function automatic int calc_div(input int sys_clk, input int rate);
      return sys_clk / rate - 1;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV and flags the final clock of each period.
module uart_baud_tick #(
   parameter logic [15:0] DIV = 16'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   output logic        tick,
   output logic [15:0] count
);

   assign tick = (count == DIV);

   always_ff @(posedge clk) begin
      if (rst || clr || tick)
         count <= '0;
      else
         count <= count + 16'd1;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a one-deep holding register so that
// queued frames follow each other with no idle clocks in between.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int sys_clk   = 50000000,
   parameter int rate      = 19200,
   parameter int data_bits = 8,
   parameter int parity    = 0,
   parameter int stop_bits = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr,
   input  logic [data_bits-1:0] din,
   output logic                 dout,
   output logic                 ready,
   output logic                 busy,
   output logic                 done
);

   localparam int DIV = calc_div(sys_clk, rate);
   localparam logic [3:0] LAST_DATA = 4'(data_bits - 1);
   localparam logic [3:0] LAST_STOP = 4'(stop_bits - 1);

   if (DIV < 1 || DIV > 65535) begin : g_bad_div
      $error("uart_tx_cfg: divisor out of range");
   end
   if (data_bits < 5 || data_bits > 9) begin : g_bad_width
      $error("uart_tx_cfg: data_bits must be 5..9");
   end
   if (parity < 0 || parity > 2) begin : g_bad_parity
      $error("uart_tx_cfg: parity must be 0, 1 or 2");
   end
   if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop
      $error("uart_tx_cfg: stop_bits must be 1 or 2");
   end

   tx_state_t            state, state_n;
   logic [data_bits-1:0] shift_q, shift_n;
   logic [data_bits-1:0] hold_q, hold_n;
   logic                 hold_full, hold_full_n;
   logic                 par_q, par_n;
   logic [3:0]           bit_q, bit_n;
   logic                 dout_n;
   logic                 load;
   logic                 tick;
   logic [15:0]          baud_count_unused;

   // The counter sits at zero while idle so every frame starts on a full period.
   uart_baud_tick #(
      .DIV(16'(DIV))
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == ST_IDLE),
      .tick (tick),
      .count(baud_count_unused)
   );

   assign ready = ~hold_full;
   assign busy  = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         shift_q   <= '0;
         hold_q    <= '0;
         hold_full <= 1'b0;
         par_q     <= 1'b0;
         bit_q     <= '0;
         dout      <= 1'b1;
      end else begin
         state     <= state_n;
         shift_q   <= shift_n;
         hold_q    <= hold_n;
         hold_full <= hold_full_n;
         par_q     <= par_n;
         bit_q     <= bit_n;
         dout      <= dout_n;
      end
   end

   // dout is registered, so each branch sets the level for the next bit period.
   always_comb begin
      state_n     = state;
      shift_n     = shift_q;
      hold_n      = hold_q;
      hold_full_n = hold_full;
      par_n       = par_q;
      bit_n       = bit_q;
      dout_n      = dout;
      load        = 1'b0;
      done        = 1'b0;

      case (state)
         ST_IDLE: begin
            dout_n = 1'b1;
            load   = hold_full;
         end
         ST_START: begin
            if (tick) begin
               state_n = ST_DATA;
               dout_n  = shift_q[0];
               bit_n   = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_n = shift_q >> 1;
               if (bit_q == LAST_DATA) begin
                  bit_n = '0;
                  if (parity != PAR_NONE) begin
                     state_n = ST_PARITY;
                     dout_n  = par_q;
                  end else begin
                     state_n = ST_STOP;
                     dout_n  = 1'b1;
                  end
               end else begin
                  bit_n  = bit_q + 4'd1;
                  dout_n = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_n = ST_STOP;
               dout_n  = 1'b1;
               bit_n   = '0;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_q == LAST_STOP) begin
                  done  = 1'b1;
                  bit_n = '0;
                  if (hold_full) begin
                     load = 1'b1;
                  end else begin
                     state_n = ST_IDLE;
                     dout_n  = 1'b1;
                  end
               end else begin
                  bit_n = bit_q + 4'd1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (load) begin
         shift_n     = hold_q;
         par_n       = (parity == PAR_ODD) ? ~^hold_q : ^hold_q;
         hold_full_n = 1'b0;
         state_n     = ST_START;
         dout_n      = 1'b0;
         bit_n       = '0;
      end

      // A load needs the holding register full, when ready is low, so the two never collide.
      if (wr && !hold_full) begin
         hold_full_n = 1'b1;
         hold_n      = din;
      end
   end

endmodule
